execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  decode stage presents an operation.
REQ-005 in_ready  output  1  unit can accept an operation this cycle; combinational.
REQ-006 alu_control  input  3  operation code from the ALU decoder.
REQ-007 src_a  input  WIDTH  operand A.
REQ-008 src_b  input  WIDTH  operand B.
REQ-009 rd_addr  input  5  destination register tag, carried alongside the result.
REQ-010 out_valid  output  1  result registers hold a completed operation.
REQ-011 out_ready  input  1  downstream (memory/writeback) consumes the result.
REQ-012 alu_result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered flag, 1 when alu_result is 0.
REQ-014 out_rd_addr  output  5  registered tag of the result.
REQ-015 busy  output  1  multi-cycle multiply in progress.

Function
REQ-016 Accept occurs on a rising edge where in_valid and in_ready are both 1; inputs are ignored otherwise.
REQ-017 in_ready = (state is IDLE) and (not out_valid or out_ready).
REQ-018 Codes: 000 add; 001 sub (A-B); 010 and; 011 or; 101 slt (signed A<B gives 1, else 0); 110 mul (low WIDTH bits of A*B); 100 and 111 give result 0.
REQ-019 Add, sub and mul wrap modulo 2^WIDTH with no overflow indication.
REQ-020 Single-cycle codes: result, zero, out_rd_addr load on the accepting edge; out_valid is 1 after that edge (latency 1).
REQ-021 States IDLE and MUL; accepting code 110 moves IDLE->MUL, latches operands and tag, clears the accumulator and step counter.
REQ-022 MUL performs one shift-add step per cycle over WIDTH steps; on the edge completing step WIDTH the result loads, out_valid becomes 1 and state returns to IDLE (out_valid high exactly WIDTH edges after the accepting edge).
REQ-023 busy = 1 exactly while state is MUL; in_ready = 0 while busy.
REQ-024 While out_valid=1 and out_ready=0, alu_result, zero and out_rd_addr hold stable.
REQ-025 out_valid clears on an edge with out_ready=1 unless a single-cycle op is accepted on that same edge, in which case out_valid stays 1 with the new result (full throughput, one op per cycle).
REQ-026 Consume and mul-accept on the same edge: out_valid clears, MUL starts.
REQ-027 out_ready is ignored while out_valid=0.

Reset
REQ-028 rst=1 immediately forces state IDLE, out_valid 0, alu_result 0, zero 0, out_rd_addr 0, busy 0, step counter and accumulator 0.
REQ-029 Reset during MUL aborts the operation; no result is produced after reset release.
REQ-030 in_ready is 0 while rst=1 and 1 on the first cycle after release.

Verification (WIDTH=32)
REQ-031 add 5+7, rd=3, out_ready=1 -> next cycle out_valid=1, alu_result=12, zero=0, out_rd_addr=3.
REQ-032 sub 7-7 -> result 0, zero=1; sub 0-1 -> 0xFFFFFFFF, zero=0.
REQ-033 slt A=0xFFFFFFFF, B=1 -> 1; slt A=1, B=0xFFFFFFFF -> 0; code 111 -> 0.
REQ-034 mul 3*5 -> busy=1 and in_ready=0 for 32 cycles, out_valid rises 32 edges after accept with 15; mul 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-035 out_ready=0 for 3 cycles after an add -> result held, in_ready=0; then 4 back-to-back adds with out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-036 rst asserted at step 10 of a mul -> all outputs 0 immediately, no result after release, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops with a valid/ready result register, plus an
// iterative shift-add multiplier that blocks new operations while it runs.
module execute_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       rd_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [4:0]       out_rd_addr,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
    localparam logic [2:0] OpMul = 3'b110;

    typedef enum logic {StIdle, StMul} state_t;

    state_t           r_state, w_state_next;
    logic [CntW-1:0]  r_step, w_step_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;
    logic [WIDTH-1:0] r_mcand, w_mcand_next;
    logic [WIDTH-1:0] r_mplier, w_mplier_next;
    logic [4:0]       r_mul_tag, w_mul_tag_next;
    logic             r_out_valid, w_out_valid_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             r_zero, w_zero_next;
    logic [4:0]       r_rd, w_rd_next;

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_partial;
    logic             w_accept;

    assign in_ready    = !rst && (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign busy        = (r_state == StMul);
    assign out_valid   = r_out_valid;
    assign alu_result  = r_result;
    assign zero        = r_zero;
    assign out_rd_addr = r_rd;

    always_comb begin
        w_alu = '0;
        case (alu_control)
            3'b000:  w_alu = src_a + src_b;
            3'b001:  w_alu = src_a - src_b;
            3'b010:  w_alu = src_a & src_b;
            3'b011:  w_alu = src_a | src_b;
            3'b101:  w_alu = ($signed(src_a) < $signed(src_b)) ? WIDTH'(1) : '0;
            default: w_alu = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
    assign w_partial = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_next     = r_state;
        w_step_next      = r_step;
        w_acc_next       = r_acc;
        w_mcand_next     = r_mcand;
        w_mplier_next    = r_mplier;
        w_mul_tag_next   = r_mul_tag;
        w_out_valid_next = r_out_valid;
        w_result_next    = r_result;
        w_zero_next      = r_zero;
        w_rd_next        = r_rd;

        if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (alu_control == OpMul) begin
                        w_state_next   = StMul;
                        w_step_next    = '0;
                        w_acc_next     = '0;
                        w_mcand_next   = src_a;
                        w_mplier_next  = src_b;
                        w_mul_tag_next = rd_addr;
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_result_next    = w_alu;
                        w_zero_next      = (w_alu == '0);
                        w_rd_next        = rd_addr;
                    end
                end
            end
            StMul: begin
                w_acc_next    = w_partial;
                w_mcand_next  = r_mcand << 1;
                w_mplier_next = r_mplier >> 1;
                w_step_next   = r_step + CntW'(1);
                if (r_step == LastStep) begin
                    w_state_next     = StIdle;
                    w_out_valid_next = 1'b1;
                    w_result_next    = w_partial;
                    w_zero_next      = (w_partial == '0);
                    w_rd_next        = r_mul_tag;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_step      <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_mul_tag   <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_rd        <= '0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_acc       <= w_acc_next;
            r_mcand     <= w_mcand_next;
            r_mplier    <= w_mplier_next;
            r_mul_tag   <= w_mul_tag_next;
            r_out_valid <= w_out_valid_next;
            r_result    <= w_result_next;
            r_zero      <= w_zero_next;
            r_rd        <= w_rd_next;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: vector table, directed multi-cycle sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_control = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [4:0]  rd_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result;
    logic        zero;
    logic [4:0]  out_rd_addr;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    execute_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .rd_addr     (rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .out_rd_addr (out_rd_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return 32'(a * b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        rd_addr     = rd;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int lat;
        int bc;
        drive(3'b110, a, b, rd);
        check("mul_accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 200) begin
            if (busy && !in_ready) bc++;
            tick();
            lat++;
        end
        check("mul_latency", lat, 32'd32);
        check("mul_busy_cycles", bc, 32'd32);
        check("mul_result", alu_result, ref_alu(3'b110, a, b));
        check("mul_rd", 32'(out_rd_addr), 32'(rd));
        check("mul_busy_done", 32'(busy), 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    // Behavioural model state for the random phase
    bit          m_valid;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    int          m_busy;
    logic [31:0] m_pend;
    logic [4:0]  m_pend_rd;

    initial begin
        vecs[0] = '{3'b000, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0};
        vecs[1] = '{3'b001, 32'd7, 32'd7, 5'd4, 32'd0, 1'b1};
        vecs[2] = '{3'b001, 32'd0, 32'd1, 5'd5, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 32'h00F0_1200, 1'b0};
        vecs[4] = '{3'b011, 32'hA000_0001, 32'h0500_0010, 5'd7, 32'hA500_0011, 1'b0};
        vecs[5] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd1, 1'b0};
        vecs[6] = '{3'b101, 32'd1, 32'hFFFF_FFFF, 5'd9, 32'd0, 1'b1};
        vecs[7] = '{3'b111, 32'd9, 32'd9, 5'd10, 32'd0, 1'b1};
        vecs[8] = '{3'b100, 32'd3, 32'd1, 5'd11, 32'd0, 1'b1};
        vecs[9] = '{3'b000, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'd1, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_rd", 32'(out_rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Table of single-cycle operations
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), alu_result, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            check($sformatf("vec%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
        end
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Multiplies
        run_mul(32'd3, 32'd5, 5'd12);
        run_mul(32'hFFFF_FFFF, 32'd2, 5'd13);
        run_mul(32'h1234_5678, 32'h9ABC_DEF1, 5'd14);
        tick();

        // Backpressure: result held, new requests ignored
        out_ready = 1'b0;
        drive(3'b000, 32'd20, 32'd22, 5'd9);
        tick();
        drive(3'b001, 32'd1, 32'd1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", alu_result, 32'd42);
            check("hold_rd", 32'(out_rd_addr), 32'd9);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("hold_result_end", alu_result, 32'd42);

        // Full throughput: four back-to-back adds
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 32'(i), 32'd100, 5'(16 + i));
            tick();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_result", alu_result, 32'(100 + i));
            check("b2b_rd", 32'(out_rd_addr), 32'(16 + i));
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply
        drive(3'b110, 32'd7, 32'd9, 5'd21);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", alu_result, 32'd0);
        check("abort_rd", 32'(out_rd_addr), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_release_ready", 32'(in_ready), 32'd1);
        begin
            int ovc;
            ovc = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid || busy) ovc++;
            end
            check("abort_no_result", ovc, 32'd0);
        end

        // Randomized traffic against the model
        m_valid = 1'b0;
        m_busy  = 0;
        m_res   = '0;
        m_rd    = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [2:0]  op;
            logic        acc;
            logic        exp_ready;
            logic [31:0] r;
            op = 3'($urandom_range(0, 7));
            if (($urandom % 3) != 0 && op == 3'b110) op = 3'b000;
            in_valid    = ($urandom % 4) != 0;
            alu_control = op;
            src_a       = (($urandom % 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            src_b       = (($urandom % 4) == 0) ? src_a : $urandom;
            rd_addr     = 5'($urandom);
            out_ready   = ($urandom % 3) != 0;
            #1;
            exp_ready = (m_busy == 0) && (!m_valid || out_ready);
            check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            acc = in_valid && exp_ready;
            r   = ref_alu(op, src_a, src_b);
            tick();
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                    m_rd    = m_pend_rd;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (acc) begin
                    if (op == 3'b110) begin
                        m_busy    = 32;
                        m_pend    = r;
                        m_pend_rd = rd_addr;
                    end else begin
                        m_valid = 1'b1;
                        m_res   = r;
                        m_rd    = rd_addr;
                    end
                end
            end
            check("rnd_valid", 32'(out_valid), 32'(m_valid));
            check("rnd_busy", 32'(busy), 32'(m_busy != 0));
            if (m_valid) begin
                check("rnd_result", alu_result, m_res);
                check("rnd_zero", 32'(zero), 32'(m_res == 32'd0));
                check("rnd_rd", 32'(out_rd_addr), 32'(m_rd));
            end
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
